mac_dot_ctrl: RTL and testbench
===============================

Name: mac_dot_ctrl

Overview:
Sequencer for the 4-bit multiply / 9-bit accumulate datapath. It runs one dot product of programmable length over a valid/ready operand stream and presents the final accumulator value on a valid/ready result port. The block owns an enable-gated, clearable MAC datapath, so accumulation advances only on accepted beats. It sits between an operand source (vector fetch/FIFO) and a result consumer.

Parameters:
DATA_W, 4, operand width (unsigned).
ACC_W, 9, accumulator and result width.
LEN_W, 4, width of the length field; maximum vector length is 2^LEN_W-1.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
len  in  LEN_W  number of operand pairs; sampled with start.
busy  out  1  high in every state except IDLE.
in_valid  in  1  operand pair valid.
in_ready  out  1  high only in RUN.
in_a  in  DATA_W  operand A.
in_b  in  DATA_W  operand B.
out_valid  out  1  result valid; high only in DONE.
out_ready  in  1  consumer accepts the result.
out_acc  out  ACC_W  final accumulator value.
out_ovf  out  1  sticky flag: an accumulation exceeded 2^ACC_W-1 during this run.

Behaviour:
- Reset (asynchronous, any state, including mid-run): state=IDLE; accumulator, beat counter, latched length and ovf all 0; busy=0, in_ready=0, out_valid=0, out_acc=0, out_ovf=0.
- IDLE: start=1 with len!=0 -> latch len, go to CLEAR. start=1 with len==0 -> go to DONE with acc=0 and ovf=0. start=0 -> stay in IDLE.
- CLEAR (1 cycle): acc<=0, cnt<=0, ovf<=0, then go to RUN.
- RUN: in_ready=1. A beat is accepted when in_valid && in_ready. On each beat: acc<=acc+in_a*in_b, with the unsigned product being 2*DATA_W bits zero-extended; cnt<=cnt+1. If the accepted beat has cnt==len_latched-1, go to DONE. No beat -> hold all state. in_valid bubbles are allowed.
- Result latency: out_valid asserts the cycle after the last beat is accepted.
- DONE: out_valid=1. out_acc and out_ovf hold stable until out_ready=1, then go to IDLE on the next edge. Stalling on out_ready is unbounded.
- start is ignored outside IDLE. start in the same cycle as the DONE->IDLE handshake is ignored and must be reissued.
- Overflow: ovf is set when the (ACC_W+1)-bit sum has a carry out. ovf is sticky for the run and cleared in CLEAR, or at the len==0 entry to DONE.
- Default arithmetic wraps modulo 2^ACC_W.
- out_acc/out_ovf show the live accumulator/flag when not in DONE; consumers must qualify them with out_valid.

Optional Feature:
Macro: MAC_DOT_SAT_EN.
- Defined: on overflow, acc saturates at 2^ACC_W-1 and stays there for the rest of the run; ovf is still set.
- Undefined: the sum wraps modulo 2^ACC_W and ovf is set.
- Port list and timing are identical in both builds.

Decomposition:
- Shared package/include mac_pkg holds: DATA_W/ACC_W/LEN_W defaults; state encoding constants ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_RUN=2'd2, ST_DONE=2'd3.
- One sub-module, mac_dp: operands, en, clr -> registered acc and sticky ovf. It contains the multiplier, the adder with carry out and the saturate/wrap select.
- mac_dot_ctrl holds the FSM, beat counter, length latch and handshake logic.

Test Plan:
- Reset mid-RUN after 2 beats of (3,4) -> next cycle busy=0, out_valid=0, out_acc=0; a subsequent len=1 run with (2,5) -> out_acc=10.
- start, len=3, beats (1,2),(3,4),(5,6) back-to-back -> out_valid one cycle after third beat, out_acc=44, out_ovf=0.
- start, len=3, beats of (15,15) -> out_acc=163, out_ovf=1 (wrap build); out_acc=511, out_ovf=1 (MAC_DOT_SAT_EN build).
- len=2 with in_valid bubbles (valid low 3 cycles between beats) of (7,7),(2,3) -> out_acc=55, acc unchanged during bubbles.
- start with len=0 -> DONE within 1 cycle, out_acc=0, out_ovf=0; hold out_ready=0 for 5 cycles -> out_valid/out_acc stable; start pulses during DONE are ignored.
- out_ready=1 with start=1 in the same cycle -> return to IDLE, no new run; start next cycle, len=1 with (15,1) -> out_acc=15.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and FSM state encoding for the dot-product MAC
//
// Purpose: default DATA_W/ACC_W/LEN_W and the state encoding shared by
// mac_dp and mac_dot_ctrl.
// Ports: none (package).
package mac_pkg;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 9;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dp.sv
// rtl/mac_dp.sv - enable-gated, clearable multiply/accumulate datapath
//
// Purpose: acc <= acc + a*b on en, with a sticky carry-out flag.
// Build option: MAC_DOT_SAT_EN defined -> accumulator saturates at
// 2^ACC_W-1 on overflow; undefined -> accumulator wraps modulo 2^ACC_W.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        accumulate this cycle
//   clr       zero acc and ovf (takes priority over en)
//   a, b      unsigned operands
//   acc       registered accumulator
//   ovf       sticky overflow flag
module mac_dp
    import mac_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc,
    output logic          ovf
);

    localparam int SUM_W = AW + 1;

    logic [2*DW-1:0] prod;
    logic [SUM_W-1:0] sum;
    logic             carry;
    logic [AW-1:0]    acc_next;

    always_comb begin
        prod  = a * b;
        sum   = {1'b0, acc} + SUM_W'(prod);
        carry = sum[AW];
`ifdef MAC_DOT_SAT_EN
        // Once pinned at full scale any nonzero product carries again,
        // so the accumulator stays saturated for the rest of the run.
        acc_next = carry ? {AW{1'b1}} : sum[AW-1:0];
`else
        acc_next = sum[AW-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= acc_next;
            ovf <= ovf | carry;
        end
    end

endmodule

// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - dot-product sequencer over a valid/ready operand stream
//
// Purpose: runs one dot product of programmable length and presents the
// final accumulator on a valid/ready result port.
// Build option: MAC_DOT_SAT_EN (saturating accumulator, see mac_dp).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, len            begin a run of len operand pairs (IDLE only)
//   busy                  high outside IDLE
//   in_valid/in_ready     operand handshake, in_ready high only in RUN
//   in_a, in_b            operand pair
//   out_valid/out_ready   result handshake, out_valid high only in DONE
//   out_acc, out_ovf      accumulator and sticky overflow (live outside DONE)
module mac_dot_ctrl
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             beat;
    logic             last_beat;
    logic             dp_clr;

    always_comb begin
        beat      = (state == ST_RUN) && in_valid;
        last_beat = beat && (cnt == len_q - LEN_W'(1));
        // A zero-length run skips CLEAR, so the datapath is cleared on the
        // same edge that enters DONE.
        dp_clr    = (state == ST_CLEAR) ||
                    ((state == ST_IDLE) && start && (len == '0));
    end

    mac_dp #(
        .DW (DATA_W),
        .AW (ACC_W)
    ) u_dp (
        .clk (clk),
        .rst (rst),
        .en  (beat),
        .clr (dp_clr),
        .a   (in_a),
        .b   (in_b),
        .acc (out_acc),
        .ovf (out_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            len_q <= len;
                            state <= ST_CLEAR;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    cnt      <= '0;
                    state    <= ST_RUN;
                    in_ready <= 1'b1;
                end
                ST_RUN: begin
                    if (beat) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_beat) begin
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here; a request
                    // coinciding with the result handshake is dropped.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - self-checking bench for mac_dot_ctrl
module tb_mac_dot_ctrl;
    import mac_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_dot_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf)
    );

    typedef struct packed {
        logic [3:0]      len;
        logic [2:0][3:0] a;
        logic [2:0][3:0] b;
        logic [1:0]      gap;
        logic [8:0]      acc;
        logic            ovf;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent accumulator model, one beat at a time.
    function automatic int model_step(input int acc, input int a, input int b);
        int s;
        s = acc + a * b;
`ifdef MAC_DOT_SAT_EN
        if (s > 511) s = 511;
`else
        s = s % 512;
`endif
        return s;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int running;
        running = 0;
        start = 1'b1;
        len   = v.len;
        tick();
        start = 1'b0;
        check({tag, " busy_clear"}, int'(busy), 1);
        check({tag, " rdy_clear"}, int'(in_ready), 0);
        tick();
        check({tag, " rdy_run"}, int'(in_ready), 1);
        for (int i = 0; i < int'(v.len); i++) begin
            in_valid = 1'b1;
            in_a     = v.a[i];
            in_b     = v.b[i];
            tick();
            running = model_step(running, int'(v.a[i]), int'(v.b[i]));
            in_valid = 1'b0;
            in_a     = 4'hF;
            in_b     = 4'hF;
            if (i != int'(v.len) - 1) begin
                check({tag, " acc_live"}, int'(out_acc), running);
                check({tag, " no_valid"}, int'(out_valid), 0);
                for (int g = 0; g < int'(v.gap); g++) begin
                    tick();
                    check({tag, " acc_bubble"}, int'(out_acc), running);
                end
            end
        end
        check({tag, " out_valid"}, int'(out_valid), 1);
        check({tag, " rdy_done"}, int'(in_ready), 0);
        check({tag, " out_acc"}, int'(out_acc), int'(v.acc));
        check({tag, " out_ovf"}, int'(out_ovf), int'(v.ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid_drop"}, int'(out_valid), 0);
        check({tag, " busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{len: 4'd1, a: {4'd0, 4'd0, 4'd2}, b: {4'd0, 4'd0, 4'd5},
                    gap: 2'd0, acc: 9'd10, ovf: 1'b0};
        vecs[1] = '{len: 4'd3, a: {4'd5, 4'd3, 4'd1}, b: {4'd6, 4'd4, 4'd2},
                    gap: 2'd0, acc: 9'd44, ovf: 1'b0};
`ifdef MAC_DOT_SAT_EN
        vecs[2] = '{len: 4'd3, a: {4'd15, 4'd15, 4'd15}, b: {4'd15, 4'd15, 4'd15},
                    gap: 2'd0, acc: 9'd511, ovf: 1'b1};
`else
        vecs[2] = '{len: 4'd3, a: {4'd15, 4'd15, 4'd15}, b: {4'd15, 4'd15, 4'd15},
                    gap: 2'd0, acc: 9'd163, ovf: 1'b1};
`endif
        vecs[3] = '{len: 4'd2, a: {4'd0, 4'd2, 4'd7}, b: {4'd0, 4'd3, 4'd7},
                    gap: 2'd3, acc: 9'd55, ovf: 1'b0};
        vecs[4] = '{len: 4'd1, a: {4'd0, 4'd0, 4'd15}, b: {4'd0, 4'd0, 4'd1},
                    gap: 2'd0, acc: 9'd15, ovf: 1'b0};

        tick();
        tick();
        check("rst busy", int'(busy), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_acc", int'(out_acc), 0);
        check("rst out_ovf", int'(out_ovf), 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a run after two (3,4) beats.
        start = 1'b1;
        len   = 4'd3;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        in_a     = 4'd3;
        in_b     = 4'd4;
        tick();
        tick();
        in_valid = 1'b0;
        check("midrun acc", int'(out_acc), 24);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst in_ready", int'(in_ready), 0);
        check("midrst out_acc", int'(out_acc), 0);
        tick();

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
            tick();
        end

        // Zero-length run: straight to DONE with a cleared accumulator.
        check("pre_len0 acc", int'(out_acc), 55);
        start = 1'b1;
        len   = 4'd0;
        tick();
        start = 1'b0;
        check("len0 out_valid", int'(out_valid), 1);
        check("len0 out_acc", int'(out_acc), 0);
        check("len0 out_ovf", int'(out_ovf), 0);
        check("len0 in_ready", int'(in_ready), 0);
        for (int s = 0; s < 5; s++) begin
            start = s[0];
            len   = 4'd2;
            in_valid = 1'b1;
            in_a = 4'd9;
            in_b = 4'd9;
            tick();
            check("stall out_valid", int'(out_valid), 1);
            check("stall out_acc", int'(out_acc), 0);
            check("stall busy", int'(busy), 1);
        end
        in_valid = 1'b0;

        // start coinciding with the result handshake is dropped.
        start     = 1'b1;
        len       = 4'd1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("hs busy", int'(busy), 0);
        check("hs out_valid", int'(out_valid), 0);
        tick();
        check("hs no_run busy", int'(busy), 0);
        check("hs no_run in_ready", int'(in_ready), 0);

        run_vec(vecs[4], "vec4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
